// File: rtl/ram8_loader.sv
// ram8_loader: assembles a valid/ready byte stream into 16-bit words and writes
// them to consecutive RAM8 locations from a programmable base, wrapping modulo 8.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start               begin a burst (sampled only when idle)
//   i_start_addr          first RAM address written
//   i_length              words to write; 0 = none, values above depth clamp to depth
//   i_byte_valid/i_byte_in, o_byte_ready   upstream byte handshake
//   o_ram_load, o_ram_address, o_ram_in    drive RAM8 load/address/in directly
//   o_busy                burst in progress
//   o_done                one-cycle pulse at burst completion
//   o_word_count          words written in the current/last burst
module ram8_loader #(
  parameter bit LSB_FIRST = 1'b1,
  parameter int ADDR_W    = 3,
  parameter int CNT_W     = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [CNT_W-1:0]  i_length,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_in,
  output logic              o_byte_ready,
  output logic              o_ram_load,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [15:0]       o_ram_in,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_word_count
);
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, WRITE, DONE} state_t;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_len;
  logic [7:0]        r_a;
  logic              r_byte_ready;
  logic              r_ram_load;
  logic [ADDR_W-1:0] r_ram_address;
  logic [15:0]       r_ram_in;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_word_count;
  logic [CNT_W-1:0]  w_len;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              w_xfer;
  assign w_len      = (i_length > DEPTH) ? DEPTH : i_length;
  assign w_next_cnt = r_word_count + 1'b1;
  // byte_ready is registered and high only in GET_A/GET_B, so it alone qualifies a transfer
  assign w_xfer     = i_byte_valid && r_byte_ready;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_a           <= '0;
      r_byte_ready  <= 1'b0;
      r_ram_load    <= 1'b0;
      r_ram_address <= '0;
      r_ram_in      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_word_count  <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_addr       <= i_start_addr;
          r_len        <= w_len;
          r_word_count <= '0;
          if (w_len == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state      <= GET_A;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        GET_A: if (w_xfer) begin
          r_a     <= i_byte_in;
          r_state <= GET_B;
        end
        GET_B: if (w_xfer) begin
          r_byte_ready  <= 1'b0;
          r_ram_load    <= 1'b1;
          r_ram_address <= r_addr;
          r_ram_in      <= LSB_FIRST ? {i_byte_in, r_a} : {r_a, i_byte_in};
          r_state       <= WRITE;
        end
        WRITE: begin
          r_ram_load   <= 1'b0;
          r_word_count <= w_next_cnt;
          r_addr       <= r_addr + 1'b1;
          if (w_next_cnt == r_len) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state      <= GET_A;
            r_byte_ready <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_byte_ready  = r_byte_ready;
  assign o_ram_load    = r_ram_load;
  assign o_ram_address = r_ram_address;
  assign o_ram_in      = r_ram_in;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_word_count  = r_word_count;
endmodule

// File: doc/ram8_loader.md
Name: ram8_loader

Overview:
- Upstream write-sequencer stage for the 8 x 16-bit RAM8 block.
- Accepts a byte stream over a valid/ready handshake and assembles byte pairs into 16-bit words.
- Writes each word into consecutive RAM8 locations starting from a programmable base address, wrapping modulo 8.
- Outputs drive RAM8's load/address/in pins directly; used to bulk-load data or program images from a serial source.

Parameters:
- LSB_FIRST, 1, 1 = first byte of each pair is bits [7:0], 0 = first byte is bits [15:8]
- ADDR_W, 3, RAM address width (depth = 2**ADDR_W = 8)
- CNT_W, 4, width of length/count fields (must hold value 8)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a load burst; sampled only in IDLE
- start_addr  input  3  first RAM address written
- length  input  4  number of words to write; 0 = no writes, values >8 clamp to 8
- byte_valid  input  1  upstream byte available
- byte_in  input  8  upstream byte
- byte_ready  output  1  loader accepts byte this cycle
- ram_load  output  1  to RAM8 load
- ram_address  output  3  to RAM8 address
- ram_in  output  16  to RAM8 in
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst completion
- word_count  output  4  words written in current/last burst

Behaviour:
- One clock, reset synchronous active-high. Reset (including mid-burst) forces: state IDLE, byte_ready=0, ram_load=0, ram_address=0, ram_in=0, busy=0, done=0, word_count=0. A partially assembled word is discarded and no write is issued.
- States: IDLE, GET_A, GET_B, WRITE, DONE.
- IDLE: byte_ready=0, busy=0. On start=1:
  - latch addr<=start_addr, len<=min(length,8), word_count<=0.
  - If len==0 go to DONE, else go to GET_A.
- GET_A: byte_ready=1, busy=1. A byte transfers only when byte_valid&&byte_ready at a rising edge. Transfer stores byte A and moves to GET_B; otherwise hold.
- GET_B: byte_ready=1. On transfer, store byte B and move to WRITE.
- WRITE: byte_ready=0, ram_load=1 for exactly this one cycle.
  - ram_address=addr.
  - ram_in={B,A} if LSB_FIRST=1, else {A,B}.
  - At the edge: word_count+1, addr<=(addr+1) mod 8 (7 wraps to 0).
  - Go to DONE if the new count equals len, else GET_A.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- ram_load=0 in all states except WRITE.
- ram_address and ram_in hold their last written values outside WRITE.
- word_count holds its value after DONE until the next accepted start.
- start is ignored in any state other than IDLE.
- byte_ready never asserts outside GET_A/GET_B. Bytes offered at other times are not consumed, and upstream must hold them.
- Throughput: minimum 3 cycles per word (A, B, write). A full 8-word burst with byte_valid held high takes 1 (start) + 24 + 1 (DONE) cycles.
- Latency from accepting byte B to ram_load: 1 cycle.
- Downstream RAM8 captures on the same rising edge that ends the WRITE cycle. The loader never asserts ram_load while reset is high.
- Upstream stalls (byte_valid=0) may last any number of cycles with no timeout.

Test Plan:
- Reset, then start with start_addr=0, length=2, LSB_FIRST=1, bytes 0x34,0x12,0xCD,0xAB back-to-back -> writes addr0=0x1234 and addr1=0xABCD, each with a one-cycle ram_load; done pulses once; word_count=2; RAM8 readback matches.
- start_addr=6, length=4, words 0x0006,0x0007,0x0000,0x0001 -> writes go to addresses 6,7,0,1 (wrap); done after the 4th write; word_count=4.
- length=0 -> no ram_load; done pulses on the cycle after start; busy never high.
- length=12 with 8 words supplied -> exactly 8 writes covering all addresses; done; word_count=8; any 9th byte is left un-acked (byte_ready=0).
- byte_valid toggled 1,0,0,1 between the bytes of one word -> ram_load occurs only after both bytes are accepted; the value is correct; no extra bytes are consumed.
- Assert reset one cycle after byte A is accepted -> all outputs 0 on the next cycle, no ram_load. A new burst after reset writes a fresh word; stale byte A is not used.
